// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU command sequencer.
//   - state_t     : sequencer FSM states (2-bit encoding)
//   - SEL_*       : ALU in_sel codes {persist, load, reset}
//   - OP_W/DATA_W : one-hot op width and data width
//   - cmd_t       : one queued command (carries a chain flag when
//                   ALU_SEQ_CHAIN_EN is defined)
//   - is_one_hot  : legality test applied to a command's op before it runs
package alu_seq_pkg;

  localparam int OP_W   = 7;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EXEC = 2'b10,
    RESP = 2'b11
  } state_t;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
    logic              chain;
`endif
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  function automatic logic is_one_hot(input logic [OP_W-1:0] op);
    return $countones(op) == 1;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous show-ahead FIFO for queued commands.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i (ignored when full)
//   wdata_i   : entry to write
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : current head entry, valid whenever empty_o is low
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; the count and pointers decide
  // which entries are meaningful, so resetting the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues one-hot ALU commands and walks the shared ALU
// through LOAD -> EXEC -> capture, returning each result on a valid/ready
// channel. One command is in flight at a time.
//   clk, rst              : clock, asynchronous active-high reset
//   on                    : global enable; low freezes FSM/pop, pushes still accepted
//   cmd_valid/cmd_ready   : command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b  : one-hot op and operands
//   cmd_chain             : only with ALU_SEQ_CHAIN_EN; operand 1 = previous result
//   res_valid/res_ready   : result handshake
//   res_data, res_op      : captured ALU result and the op that produced it
//   alu_in_sel, alu_num1, alu_num2, alu_out_sel : drive the ALU
//   alu_out               : ALU result, valid ALU_LAT cycles into EXEC
//   busy                  : FSM not IDLE or commands queued
//   err_op                : sticky, a non-one-hot op was dropped
// Optional feature macro: ALU_SEQ_CHAIN_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic              cmd_chain,
`endif
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [OP_W-1:0]   res_op,
  output logic [2:0]        alu_in_sel,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [OP_W-1:0]   alu_out_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy,
  output logic              err_op
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [2:0]        alu_in_sel_q, alu_in_sel_d;
  logic [DATA_W-1:0] alu_num1_q, alu_num1_d;
  logic [DATA_W-1:0] alu_num2_q, alu_num2_d;
  logic [OP_W-1:0]   alu_out_sel_q, alu_out_sel_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [OP_W-1:0]   res_op_q, res_op_d;
  logic              err_op_q, err_op_d;

  cmd_t push_cmd, head;
  logic fifo_full, fifo_empty, fifo_pop;

  always_comb begin
    push_cmd    = '0;
    push_cmd.op = cmd_op;
    push_cmd.a  = cmd_a;
    push_cmd.b  = cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
    push_cmd.chain = cmd_chain;
`endif
  end

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: every signal written here gets its default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    op_d          = op_q;
    alu_in_sel_d  = alu_in_sel_q;
    alu_num1_d    = alu_num1_q;
    alu_num2_d    = alu_num2_q;
    alu_out_sel_d = alu_out_sel_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_op_d      = res_op_q;
    err_op_d      = err_op_q;
    fifo_pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (on && !fifo_empty) begin
          fifo_pop = 1'b1;
          if (!is_one_hot(head.op)) begin
            err_op_d = 1'b1;
          end else begin
            op_d       = head.op;
            alu_num2_d = head.b;
`ifdef ALU_SEQ_CHAIN_EN
            // res_data_q still holds the previous result (0 after reset).
            alu_num1_d = head.chain ? res_data_q : head.a;
`else
            alu_num1_d = head.a;
`endif
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (on) begin
          alu_out_sel_d = op_q;
          lat_cnt_d     = '0;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (on) begin
          if (lat_cnt_q == CNT_W'(ALU_LAT - 1)) begin
            res_data_d  = alu_out;
            res_op_d    = op_q;
            res_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            lat_cnt_d = lat_cnt_q + CNT_W'(1);
          end
        end
      end
      RESP: begin
        // The handshake may finish even while on is low.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // in_sel is registered against the upcoming state so the ALU sees the
    // phase code for the whole cycle; it freezes with the FSM when on is low.
    if (on) alu_in_sel_d = (state_d == LOAD) ? SEL_LOAD : SEL_PERSIST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lat_cnt_q     <= '0;
      op_q          <= '0;
      alu_in_sel_q  <= SEL_RESET;
      alu_num1_q    <= '0;
      alu_num2_q    <= '0;
      alu_out_sel_q <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_op_q      <= '0;
      err_op_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      op_q          <= op_d;
      alu_in_sel_q  <= alu_in_sel_d;
      alu_num1_q    <= alu_num1_d;
      alu_num2_q    <= alu_num2_d;
      alu_out_sel_q <= alu_out_sel_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_op_q      <= res_op_d;
      err_op_q      <= err_op_d;
    end
  end

  assign cmd_ready   = ~fifo_full;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_op      = res_op_q;
  assign alu_in_sel  = alu_in_sel_q;
  assign alu_num1    = alu_num1_q;
  assign alu_num2    = alu_num2_q;
  assign alu_out_sel = alu_out_sel_q;
  assign err_op      = err_op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst, on, cmd_valid, cmd_ready, cmd_chain;
  logic [6:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [6:0] res_op;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1, alu_num2, alu_out;
  logic [6:0] alu_out_sel;
  logic       busy, err_op;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .on          (on),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
    .cmd_chain   (cmd_chain),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_op      (res_op),
    .alu_in_sel  (alu_in_sel),
    .alu_num1    (alu_num1),
    .alu_num2    (alu_num2),
    .alu_out_sel (alu_out_sel),
    .alu_out     (alu_out),
    .busy        (busy),
    .err_op      (err_op)
  );

  // Stub ALU: combinational, so its output is valid in the first EXEC cycle.
  always_comb begin
    case (alu_out_sel)
      7'b1000000: alu_out = alu_num1 + alu_num2;
      7'b0100000: alu_out = alu_num1 - alu_num2;
      7'b0010000: alu_out = alu_num1 & alu_num2;
      7'b0001000: alu_out = alu_num1 | alu_num2;
      7'b0000100: alu_out = alu_num1 ^ alu_num2;
      7'b0000010: alu_out = ~alu_num1;
      7'b0000001: alu_out = {alu_num1[6:0], 1'b0};
      default:    alu_out = 8'h00;
    endcase
  end

  // Reference: what the ALU should return for a command, by op meaning.
  function automatic logic [7:0] ref_alu(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b);
    int sum;
    if (op[6]) begin sum = int'(a) + int'(b); return sum[7:0]; end
    if (op[5]) begin sum = int'(a) - int'(b) + 256; return sum[7:0]; end
    if (op[4]) return a & b;
    if (op[3]) return a | b;
    if (op[2]) return a ^ b;
    if (op[1]) return 8'hFF - a;
    sum = int'(a) * 2;
    return sum[7:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_ready"}, cmd_ready, 1'b1);
    check({tag, " res_valid"}, res_valid, 1'b0);
    check({tag, " res_data"}, res_data, 8'h00);
    check({tag, " res_op"}, res_op, 7'h00);
    check({tag, " alu_in_sel"}, alu_in_sel, 3'b001);
    check({tag, " alu_num1"}, alu_num1, 8'h00);
    check({tag, " alu_num2"}, alu_num2, 8'h00);
    check({tag, " alu_out_sel"}, alu_out_sel, 7'h00);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " err_op"}, err_op, 1'b0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b, input logic chain);
    int k;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    cmd_valid = 1'b1;
    for (k = 0; k < 60; k++) begin
      if (cmd_ready) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    fail_timeout("push");
  endtask

  task automatic collect(input logic [7:0] exp_d, input logic [6:0] exp_op, input string name);
    int k = 0;
    res_ready = 1'b1;
    while (!res_valid && k < 60) begin @(negedge clk); k++; end
    if (!res_valid) begin
      fail_timeout(name);
    end else begin
      check({name, " data"}, res_data, exp_d);
      check({name, " op"}, res_op, exp_op);
      @(negedge clk);
    end
  endtask

  task automatic expect_silence(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check({name, " no result"}, seen, 0);
    check({name, " busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [6:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [6:0] op;
    logic [7:0] data;
  } res_t;

  vec_t vecs[7];
  res_t exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{7'b1000000, 8'h57, 8'h1A, 8'h71};
    vecs[1] = '{7'b0100000, 8'h10, 8'h20, 8'hF0};
    vecs[2] = '{7'b0010000, 8'hF0, 8'h3C, 8'h30};
    vecs[3] = '{7'b0001000, 8'h0F, 8'h30, 8'h3F};
    vecs[4] = '{7'b0000100, 8'hFF, 8'h0F, 8'hF0};
    vecs[5] = '{7'b0000010, 8'h5A, 8'h00, 8'hA5};
    vecs[6] = '{7'b0000001, 8'h81, 8'h00, 8'h02};

    rst = 1'b1; on = 1'b1; cmd_valid = 1'b0; cmd_chain = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single command with exact phase timing.
    res_ready = 1'b1;
    cmd_op = vecs[0].op; cmd_a = vecs[0].a; cmd_b = vecs[0].b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("single idle in_sel", alu_in_sel, 3'b100);
    check("single busy", busy, 1'b1);
    @(negedge clk);
    check("single load in_sel", alu_in_sel, 3'b010);
    check("single load num1", alu_num1, 8'h57);
    check("single load num2", alu_num2, 8'h1A);
    @(negedge clk);
    check("single exec in_sel", alu_in_sel, 3'b100);
    check("single exec out_sel", alu_out_sel, 7'b1000000);
    check("single exec res_valid", res_valid, 1'b0);
    @(negedge clk);
    check("single res_valid", res_valid, 1'b1);
    check("single res_data", res_data, 8'h71);
    check("single res_op", res_op, 7'b1000000);
    @(negedge clk);
    check("single consumed", res_valid, 1'b0);
    check("single idle busy", busy, 1'b0);

    // Table of ops, one at a time.
    for (int i = 1; i < 7; i++) begin
      push(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      collect(vecs[i].exp, vecs[i].op, $sformatf("vec%0d", i));
    end

    // Fill: five back-to-back, consumer stalled.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
    check("fill cmd_ready", cmd_ready, 1'b0);
    check("fill busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) collect(vecs[i].exp, vecs[i].op, $sformatf("fill%0d", i));

    // Illegal op between two legal ones.
    push(vecs[1].op, vecs[1].a, vecs[1].b, 1'b0);
    push(7'b0000011, 8'h12, 8'h34, 1'b0);
    push(vecs[2].op, vecs[2].a, vecs[2].b, 1'b0);
    collect(vecs[1].exp, vecs[1].op, "illegal first");
    collect(vecs[2].exp, vecs[2].op, "illegal second");
    check("illegal err_op", err_op, 1'b1);
    expect_silence("illegal", 8);

    // Backpressure: outputs frozen for 10 cycles, no further pop.
    res_ready = 1'b0;
    push(vecs[3].op, vecs[3].a, vecs[3].b, 1'b0);
    push(vecs[4].op, vecs[4].a, vecs[4].b, 1'b0);
    begin
      int k = 0;
      while (!res_valid && k < 60) begin @(negedge clk); k++; end
      if (!res_valid) fail_timeout("backpressure wait");
    end
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp hold %0d", i),
            {res_valid, res_data, res_op, alu_in_sel, alu_num1, alu_num2, alu_out_sel},
            {1'b1, 8'h3F, 7'b0001000, 3'b100, 8'h0F, 8'h30, 7'b0001000});
      @(negedge clk);
    end
    check("bp busy", busy, 1'b1);
    collect(vecs[3].exp, vecs[3].op, "bp first");
    collect(vecs[4].exp, vecs[4].op, "bp second");

    // Reset while the head command is in EXEC and two are queued.
    res_ready = 1'b0;
    push(vecs[0].op, vecs[0].a, vecs[0].b, 1'b0);
    push(vecs[1].op, vecs[1].a, vecs[1].b, 1'b0);
    push(vecs[2].op, vecs[2].a, vecs[2].b, 1'b0);
    check("mid exec out_sel", alu_out_sel, vecs[0].op);
    check("mid exec res_valid", res_valid, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values("mid reset");
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    expect_silence("after reset", 10);

`ifdef ALU_SEQ_CHAIN_EN
    // Chain: second add uses the first result as operand 1.
    push(7'b1000000, 8'h05, 8'h03, 1'b0);
    push(7'b1000000, 8'h77, 8'h02, 1'b1);
    collect(8'h08, 7'b1000000, "chain first");
    begin
      int k = 0;
      while (alu_in_sel != 3'b010 && k < 20) begin @(negedge clk); k++; end
      if (alu_in_sel != 3'b010) fail_timeout("chain load");
      else check("chain load num1", alu_num1, 8'h08);
    end
    collect(8'h0A, 7'b1000000, "chain second");
`endif

    // Randomized traffic against the scoreboard.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    begin
      int         pushed = 0;
      int         cyc = 0;
      logic       model_err = 1'b0;
      logic [7:0] model_last = 8'h00;
      logic [7:0] opnd1;
      logic       accept;
      res_t       r;
      cmd_valid = 1'b0;
      while ((pushed < 60 || exp_q.size() > 0) && cyc < 5000) begin
        cyc++;
        on        = (pushed >= 60) ? 1'b1 : ($urandom_range(0, 7) != 0);
        res_ready = (pushed >= 60) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (!cmd_valid && pushed < 60 && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
              0:       cmd_op = 7'b0000000;
              1:       cmd_op = 7'b0000011;
              2:       cmd_op = 7'b1010000;
              default: cmd_op = 7'b1111111;
            endcase
          end else begin
            cmd_op = 7'(1 << $urandom_range(0, 6));
          end
          cmd_a     = 8'($urandom);
          cmd_b     = 8'($urandom);
          cmd_chain = 1'($urandom_range(0, 1));
          cmd_valid = 1'b1;
        end
        accept = cmd_valid && cmd_ready;
        if (accept) begin
          pushed++;
          if ($countones(cmd_op) != 1) begin
            model_err = 1'b1;
          end else begin
`ifdef ALU_SEQ_CHAIN_EN
            opnd1 = cmd_chain ? model_last : cmd_a;
`else
            opnd1 = cmd_a;
`endif
            r.op   = cmd_op;
            r.data = ref_alu(cmd_op, opnd1, cmd_b);
            model_last = r.data;
            exp_q.push_back(r);
          end
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rand unexpected result: got 0x%0h expected none", res_data);
          end else begin
            r = exp_q.pop_front();
            check("rand data", res_data, r.data);
            check("rand op", res_op, r.op);
          end
        end
        @(negedge clk);
        if (accept) cmd_valid = 1'b0;
      end
      check("rand drained", exp_q.size(), 0);
      check("rand err_op", err_op, model_err);
      on = 1'b1;
      expect_silence("rand end", 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
